// File: rtl/score_bcd_conv.sv
// score_bcd_conv: sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Feeds the seven-segment decoders. Each 4-bit slice of digits drives one decoder
// input, and the matching digit_en bit blanks leading zeros.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   start, value   - conversion request and the binary operand (sampled on accept)
//   busy, done     - conversion in progress / one-cycle result strobe
//   digits         - BCD result, [3:0] is the ones digit
//   digit_en       - per-digit display enable (leading-zero blanking)
//   overflow       - last accepted value exceeded 10^DIGITS-1 (digits forced to 9s)
module score_bcd_conv #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  overflow
);

    localparam int unsigned BW     = 4 * DIGITS;
    localparam int unsigned MAXVAL = (10 ** DIGITS) - 1;
    localparam int unsigned CW     = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_sh;
    logic [DIGITS-1:0] en_nx;
    logic [CW-1:0]   cnt;
    logic            ovf_pending;
    logic            last_shift;

    assign last_shift = (cnt == CW'(WIDTH - 1));

    // Add-3 correction on every digit in parallel, then shift in the next binary bit.
    always_comb begin
        logic any_nz;
        bcd_adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_sh = {bcd_adj[BW-2:0], bin[WIDTH-1]};

        // A digit is shown if it or any more-significant digit is nonzero.
        any_nz = 1'b0;
        en_nx  = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            any_nz   = any_nz | (bcd_sh[4*i +: 4] != 4'd0);
            en_nx[i] = any_nz;
        end
        en_nx[0] = 1'b1;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last_shift) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            digits      <= '0;
            digit_en    <= DIGITS'(1);
            bin         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        bin         <= value;
                        bcd         <= '0;
                        cnt         <= '0;
                        ovf_pending <= (32'(value) > MAXVAL);
                    end
                end
                SHIFT: begin
                    bin <= bin << 1;
                    bcd <= bcd_sh;
                    cnt <= cnt + CW'(1);
                    if (last_shift) begin
                        digits   <= ovf_pending ? {DIGITS{4'h9}} : bcd_sh;
                        digit_en <= ovf_pending ? '1 : en_nx;
                        overflow <= ovf_pending;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_conv.sv
// tb_score_bcd_conv: randomized and directed checks of score_bcd_conv against an
// arithmetic decimal-digit reference model (WIDTH=14, DIGITS=4).
module tb_score_bcd_conv;

    localparam int unsigned WIDTH  = 14;
    localparam int unsigned DIGITS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  value;
    logic              busy;
    logic              done;
    logic [15:0]       digits;
    logic [3:0]        digit_en;
    logic              overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected held outputs from the most recent completed conversion (or reset).
    logic [15:0] exp_digits;
    logic [3:0]  exp_en;
    logic        exp_ovf;

    score_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy), .done(done), .digits(digits),
        .digit_en(digit_en), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref_digits(input int v);
        logic [15:0] r;
        int p;
        if (v > 9999) return 16'h9999;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_en(input int v);
        logic [3:0] e;
        int p;
        if (v > 9999) return 4'hF;
        e = 4'b0001;
        p = 10;
        for (int i = 1; i < 4; i++) begin
            if (v >= p) e[i] = 1'b1;
            p = p * 10;
        end
        return e;
    endfunction

    task automatic expect_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ovf"},  32'(overflow), 32'd0);
        check({tag, "_dig"},  32'(digits), 32'h0000);
        check({tag, "_en"},   32'(digit_en), 32'b0001);
        exp_digits = 16'h0000;
        exp_en     = 4'b0001;
        exp_ovf    = 1'b0;
    endtask

    // Start one conversion at the next edge and check latency, busy span, hold and result.
    task automatic run(input int v, input string tag);
        int  lat;
        int  busy_cnt;
        bit  stable;
        @(negedge clk);
        start = 1'b1;
        value = WIDTH'(v);
        @(posedge clk);                         // E0
        @(negedge clk);
        start = 1'b0;
        value = WIDTH'($urandom);               // must not affect this conversion
        busy_cnt = busy ? 1 : 0;
        stable   = (digits === exp_digits) && (digit_en === exp_en) && (overflow === exp_ovf)
                   && !done;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
            if (digits !== exp_digits || digit_en !== exp_en || overflow !== exp_ovf) stable = 0;
        end
        check({tag, "_latency"}, 32'(lat), 32'd14);
        check({tag, "_hold"}, 32'(stable), 32'd1);
        check({tag, "_dig"}, 32'(digits), 32'(ref_digits(v)));
        check({tag, "_en"},  32'(digit_en), 32'(ref_en(v)));
        check({tag, "_ovf"}, 32'(overflow), 32'(v > 9999));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_busy_span"}, 32'(busy_cnt), 32'd15);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        exp_digits = ref_digits(v);
        exp_en     = ref_en(v);
        exp_ovf    = (v > 9999);
    endtask

    initial begin
        int dir_vals[$];
        int gaps;
        int last_c;
        int ndone;
        bit abort_ok;

        rst = 1'b1; start = 1'b0; value = '0;
        exp_digits = '0; exp_en = 4'b0001; exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        expect_reset_values("reset");

        run(1234, "v1234");
        check("v1234_en_full", 32'(digit_en), 32'hF);

        dir_vals = '{0, 7, 905, 60, 9999, 10000, 16383, 10, 100, 1000, 9};
        foreach (dir_vals[i]) run(dir_vals[i], $sformatf("dir%0d", dir_vals[i]));

        // Randomized values, half biased near the overflow boundary.
        for (int i = 0; i < 24; i++) begin
            int v;
            v = (i % 2 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(9990, 10010));
            run(v, $sformatf("rnd%0d", i));
        end

        // Starts while busy (mid-shift and during DONE) are ignored.
        @(negedge clk);
        start = 1'b1; value = 14'd42;
        @(posedge clk);                         // E0
        @(negedge clk);
        start = 1'b0; value = 14'd77;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = (k == 2 || k == 14);        // sampled at E3 and E15
            if (k == 14) begin
                check("ign_done", 32'(done), 32'd1);
                check("ign_dig", 32'(digits), 32'h0042);
            end
        end
        start = 1'b0;
        check("ign_no_accept", 32'(busy), 32'd0);
        check("ign_hold", 32'(digits), 32'h0042);
        exp_digits = 16'h0042; exp_en = 4'b0011; exp_ovf = 1'b0;

        // Held-high start: done every WIDTH+2 cycles.
        @(negedge clk);
        start = 1'b1; value = 14'd5;
        last_c = -1; ndone = 0; gaps = 0;
        for (int c = 0; c < 80 && ndone < 3; c++) begin
            @(negedge clk);
            if (done) begin
                if (last_c >= 0) check($sformatf("b2b_gap%0d", ndone), 32'(c - last_c), 32'd16);
                last_c = c;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        check("b2b_count", 32'(ndone), 32'd3);
        check("b2b_dig", 32'(digits), 32'h0005);
        repeat (3) @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);
        exp_digits = 16'h0005; exp_en = 4'b0001; exp_ovf = 1'b0;

        // Reset during SHIFT aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; value = 14'd8765;
        @(posedge clk);                         // E0
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);              // after E5
        rst = 1'b1;                             // sampled at E6
        @(negedge clk);
        expect_reset_values("abort");
        rst = 1'b0;
        abort_ok = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) abort_ok = 0;
        end
        check("abort_no_done", 32'(abort_ok), 32'd1);
        run(31, "after_abort");
        check("after_abort_en", 32'(digit_en), 32'b0011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
